// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with a double-buffered digit store.
// Outputs are registered (same edge as state entry); writes are stalled via wr_ready while a commit is pending.
module seg_scan_ctrl #(
  parameter int SCAN_TICKS  = 400000,
  parameter int BLANK_TICKS = 4000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       commit,
  output logic       pending,
  output logic       frame_done,
  output logic [6:0] seg,
  output logic [3:0] ga
);

  localparam int MAXT = (SCAN_TICKS > BLANK_TICKS) ? SCAN_TICKS : BLANK_TICKS;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  // With no blanking configured every slot starts directly in DRIVE.
  localparam state_t SLOT_START = (BLANK_TICKS > 0) ? BLANK : DRIVE;

  state_t          state_q, state_d;
  logic [1:0]      digit_q, digit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0][4:0] shadow_q, shadow_d;
  logic [3:0][4:0] active_q, active_d;
  logic            pending_q, pending_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      ga_q, ga_d;
  logic            frame_end;
  logic            xfer;

  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    seg_d     = 7'h7F;
    ga_d      = 4'hF;

    frame_end = (state_q == DRIVE) && (digit_q == 2'd0) && (cnt_q == SCAN_LAST);
    xfer      = pending_q && (frame_end || (state_q == IDLE));

    if (wr_valid && !pending_q) begin
      shadow_d[wr_addr] = wr_data;
    end

    // A commit seen while a transfer is happening belongs to the old request.
    if (xfer) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (commit) begin
      pending_d = 1'b1;
    end

    if (!enable) begin
      state_d = IDLE;
      digit_d = 2'd3;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SLOT_START;
          digit_d = 2'd3;
          cnt_d   = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DRIVE: begin
          if (cnt_q == SCAN_LAST) begin
            state_d = SLOT_START;
            digit_d = digit_q - 2'd1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          digit_d = 2'd3;
          cnt_d   = '0;
        end
      endcase
    end

    // Decode from the post-transfer bank so a new frame shows new data on its first drive.
    if (state_d == DRIVE) begin
      ga_d[digit_d] = 1'b0;
      if (!active_d[digit_d][4]) begin
        seg_d = hex2seg(active_d[digit_d][3:0]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      digit_q   <= 2'd3;
      cnt_q     <= '0;
      shadow_q  <= {4{5'b10000}};
      active_q  <= {4{5'b10000}};
      pending_q <= 1'b0;
      seg_q     <= 7'h7F;
      ga_q      <= 4'hF;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      ga_q      <= ga_d;
    end
  end

  assign wr_ready   = ~pending_q;
  assign pending    = pending_q;
  assign frame_done = frame_end;
  assign seg        = seg_q;
  assign ga         = ga_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: SCAN=4/BLANK=2 instance plus a BLANK=0 instance.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, enable, wr_valid, commit;
  logic [1:0] wr_addr;
  logic [4:0] wr_data;
  logic       wr_ready, pending, frame_done;
  logic [6:0] seg;
  logic [3:0] ga;

  logic       b_enable, b_wr_valid, b_commit;
  logic [1:0] b_wr_addr;
  logic [4:0] b_wr_data;
  logic       b_wr_ready, b_pending, b_frame_done;
  logic [6:0] b_seg;
  logic [3:0] b_ga;

  int checks   = 0;
  int failures = 0;
  int c;

  logic [3:0] lga  [4];
  logic [6:0] lseg [4];

  seg_scan_ctrl #(.SCAN_TICKS(4), .BLANK_TICKS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .pending(pending), .frame_done(frame_done), .seg(seg), .ga(ga)
  );

  seg_scan_ctrl #(.SCAN_TICKS(4), .BLANK_TICKS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(b_enable),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .commit(b_commit), .pending(b_pending), .frame_done(b_frame_done), .seg(b_seg), .ga(b_ga)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] eg, input logic [6:0] es);
    checks++;
    assert (ga === eg) else begin
      failures++;
      $error("FAIL %s ga observed=%b expected=%b", tag, ga, eg);
    end
    checks++;
    assert (seg === es) else begin
      failures++;
      $error("FAIL %s seg observed=%b expected=%b", tag, seg, es);
    end
  endtask

  task automatic chk_b(input string tag, input logic [3:0] eg, input logic [6:0] es);
    checks++;
    assert (b_ga === eg) else begin
      failures++;
      $error("FAIL %s ga observed=%b expected=%b", tag, b_ga, eg);
    end
    checks++;
    assert (b_seg === es) else begin
      failures++;
      $error("FAIL %s seg observed=%b expected=%b", tag, b_seg, es);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic step_to(input int t);
    while (c < t) adv(1);
  endtask

  initial begin
    lga[0] = 4'b0111; lseg[0] = 7'b1001111;
    lga[1] = 4'b1011; lseg[1] = 7'b0010010;
    lga[2] = 4'b1101; lseg[2] = 7'b0000110;
    lga[3] = 4'b1110; lseg[3] = 7'b1001100;

    rst_n = 1'b0; enable = 1'b0; wr_valid = 1'b0; commit = 1'b0;
    wr_addr = 2'd0; wr_data = 5'd0;
    b_enable = 1'b0; b_wr_valid = 1'b0; b_commit = 1'b0;
    b_wr_addr = 2'd0; b_wr_data = 5'd0;
    c = 0;

    #12;
    chk_disp("reset_disp", 4'hF, 7'h7F);
    chk1("reset_pending", pending, 1'b0);
    chk1("reset_wr_ready", wr_ready, 1'b1);
    chk1("reset_frame_done", frame_done, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    adv(1);

    // Load 1,2,3,4 into digits 3..0; last write shares its cycle with commit.
    wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 5'h01; adv(1);
    wr_addr = 2'd2; wr_data = 5'h02; adv(1);
    wr_addr = 2'd1; wr_data = 5'h03; adv(1);
    wr_addr = 2'd0; wr_data = 5'h04; commit = 1'b1; adv(1);
    wr_valid = 1'b0; commit = 1'b0;
    chk1("load_pending_set", pending, 1'b1);
    chk1("load_wr_ready_low", wr_ready, 1'b0);
    chk_disp("load_idle_dark", 4'hF, 7'h7F);
    adv(1);
    chk1("idle_xfer_pending_clr", pending, 1'b0);

    // Frame 0: 2 dark + 4 drive cycles per digit, frame_done on cycle 23.
    c = -1;
    enable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      adv(1);
      if ((c % 6) < 2) chk_disp("f0_dark", 4'hF, 7'h7F);
      else             chk_disp("f0_drive", lga[c / 6], lseg[c / 6]);
      chk1("f0_frame_done", frame_done, (c == 23));
    end

    // Frame 1: accepted shadow write, commit mid-frame, dropped write while pending.
    adv(1);
    wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 5'h08; adv(1);
    wr_valid = 1'b0;
    chk1("f1_write_pending", pending, 1'b0);
    step_to(26);
    chk_disp("f1_old_d3", 4'b0111, 7'b1001111);
    step_to(30);
    commit = 1'b1; adv(1);
    commit = 1'b0;
    chk1("f1_commit_pending", pending, 1'b1);
    chk1("f1_commit_wr_ready", wr_ready, 1'b0);
    wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 5'h0E; adv(1);
    wr_valid = 1'b0;
    step_to(46);
    chk1("f1_fd_early", frame_done, 1'b0);
    step_to(47);
    chk1("f1_fd", frame_done, 1'b1);
    chk1("f1_fd_pending", pending, 1'b1);
    step_to(48);
    chk1("f2_pending_clr", pending, 1'b0);
    chk1("f2_wr_ready", wr_ready, 1'b1);
    step_to(50);
    chk_disp("f2_new_d3", 4'b0111, 7'b0000000);
    step_to(56);
    chk_disp("f2_d2_drop", 4'b1011, 7'b0010010);

    // Frame 2: blank digit 0 in shadow, then commit during the frame_done cycle.
    step_to(60);
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 5'h10; adv(1);
    wr_valid = 1'b0;
    step_to(71);
    chk1("f2_fd", frame_done, 1'b1);
    commit = 1'b1; adv(1);
    commit = 1'b0;
    chk1("f3_pending_held", pending, 1'b1);
    step_to(92);
    chk_disp("f3_d0_old", 4'b1110, 7'b1001100);
    step_to(95);
    chk1("f3_fd", frame_done, 1'b1);
    chk1("f3_fd_pending", pending, 1'b1);
    step_to(96);
    chk1("f4_pending_clr", pending, 1'b0);

    // Frame 4: drop enable in digit 1 drive, then restart from digit 3.
    step_to(111);
    chk_disp("f4_d1", 4'b1101, 7'b0000110);
    enable = 1'b0; adv(1);
    chk_disp("dis_dark", 4'hF, 7'h7F);
    chk1("dis_fd", frame_done, 1'b0);
    step_to(114);
    chk_disp("dis_dark2", 4'hF, 7'h7F);
    enable = 1'b1; adv(1);
    chk_disp("re_blank0", 4'hF, 7'h7F);
    step_to(116);
    chk_disp("re_blank1", 4'hF, 7'h7F);
    step_to(117);
    chk_disp("re_d3", 4'b0111, 7'b0000000);
    step_to(135);
    chk_disp("re_d0_blank", 4'b1110, 7'h7F);
    step_to(137);
    chk1("re_fd_early", frame_done, 1'b0);
    step_to(138);
    chk1("re_fd", frame_done, 1'b1);

    // Asynchronous reset mid-drive with a commit pending.
    step_to(140);
    wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 5'h05; commit = 1'b1; adv(1);
    wr_valid = 1'b0; commit = 1'b0;
    chk1("pre_rst_pending", pending, 1'b1);
    step_to(142);
    chk_disp("pre_rst_d3", 4'b0111, 7'b0000000);
    #2 rst_n = 1'b0;
    #1;
    chk_disp("async_rst_dark", 4'hF, 7'h7F);
    chk1("async_rst_pending", pending, 1'b0);
    chk1("async_rst_wr_ready", wr_ready, 1'b1);
    chk1("async_rst_fd", frame_done, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    c = -1;
    adv(1);
    chk_disp("post_rst_blank", 4'hF, 7'h7F);
    adv(2);
    chk_disp("post_rst_d3", 4'b0111, 7'h7F);
    step_to(8);
    chk_disp("post_rst_d2", 4'b1011, 7'h7F);
    chk1("post_rst_pending", pending, 1'b0);

    // No-blanking instance: digit 3 = A, others blank; 16-cycle frames.
    b_wr_valid = 1'b1; b_wr_addr = 2'd3; b_wr_data = 5'h0A; b_commit = 1'b1; adv(1);
    b_wr_valid = 1'b0; b_commit = 1'b0;
    chk1("b_pending_set", b_pending, 1'b1);
    adv(1);
    chk1("b_pending_clr", b_pending, 1'b0);
    c = -1;
    b_enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      adv(1);
      chk_b("b_scan", lga[(c % 16) / 4], ((c % 16) < 4) ? 7'b0001000 : 7'h7F);
      chk1("b_frame_done", b_frame_done, ((c % 16) == 15));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
